// File: rtl/excess3_deser_pkg.sv
// Shared types and constants for the serial excess-3 to BCD deserializer.
package excess3_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int E3_OFFSET  = 3;
  localparam int E3_MIN     = 3;
  localparam int E3_MAX     = 12;
  localparam int FRAME_BITS = 4;
  localparam int CNT_W      = 3;  // holds bit counts 0..FRAME_BITS

endpackage

// File: rtl/excess3_decode.sv
// Combinational excess-3 to BCD decoder; codes outside 3..12 flag err and give bcd 0.
module excess3_decode
  import excess3_deser_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       err
);

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    bcd = 4'd0;
    err = 1'b1;
    if (int'(code) >= E3_MIN && int'(code) <= E3_MAX) begin
      bcd = code - 4'(E3_OFFSET);
      err = 1'b0;
    end
  end

endmodule

// File: rtl/excess3_deser.sv
// Serial excess-3 frame deserializer: collects 4 MSB-first bits, decodes to BCD,
// holds the digit until consumed, and counts invalid codes and framing violations.
module excess3_deser
  import excess3_deser_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic                 s_bit,
  input  logic                 s_first,
  output logic                 s_ready,
  output logic [3:0]           bcd,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_e               state_q, state_d;
  logic [3:0]           shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bcd_q, bcd_d;
  logic                 out_err_q, out_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic       accept;
  logic       last_bit;
  logic       err_inc;
  logic [3:0] full_code;
  logic [3:0] dec_bcd;
  logic       dec_err;

  assign accept    = s_valid && s_ready;
  assign last_bit  = (cnt_q == CNT_W'(FRAME_BITS - 1));
  // The final bit lands in position 0, so decode the frame as it completes.
  assign full_code = {shift_q[3:1], s_bit};

  excess3_decode u_decode (
    .code (full_code),
    .bcd  (dec_bcd),
    .err  (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    out_err_d   = out_err_q;
    frame_err_d = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_first) begin
            shift_d = {s_bit, 3'b000};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (accept) begin
          if (s_first) begin
            frame_err_d = 1'b1;
            shift_d     = {s_bit, 3'b000};
            cnt_d       = CNT_W'(1);
          end else if (last_bit) begin
            shift_d   = full_code;
            cnt_d     = '0;
            bcd_d     = dec_bcd;
            out_err_d = dec_err;
            err_inc   = dec_err;
            state_d   = HOLD;
          end else begin
            shift_d[2'(FRAME_BITS - 1) - cnt_q[1:0]] = s_bit;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A framing error and an invalid-code entry into HOLD are mutually exclusive.
    err_count_d = err_count_q;
    if ((frame_err_d || err_inc) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      out_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      out_err_q   <= out_err_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign s_ready   = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign bcd       = bcd_q;
  assign out_err   = out_err_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_excess3_deser.sv
// Self-checking bench for excess3_deser: vector table, directed corner sequences,
// and a randomized run against a frame-level reference model.
module tb_excess3_deser;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_bit;
  logic       s_first;
  logic       out_ready;

  logic       s_ready;
  logic [3:0] bcd;
  logic       out_err;
  logic       out_valid;
  logic       frame_err;
  logic [7:0] err_count;

  logic       s_ready2;
  logic [3:0] bcd2;
  logic       out_err2;
  logic       out_valid2;
  logic       frame_err2;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_pass   = 0;

  excess3_deser dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_bit     (s_bit),
    .s_first   (s_first),
    .s_ready   (s_ready),
    .bcd       (bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  excess3_deser #(.ERR_CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_bit     (s_bit),
    .s_first   (s_first),
    .s_ready   (s_ready2),
    .bcd       (bcd2),
    .out_err   (out_err2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .frame_err (frame_err2),
    .err_count (err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits of the partial frame, the held digit, and an unbounded error tally.
  int   m_q[$];
  logic m_hold = 1'b0;
  int   m_bcd  = 0;
  logic m_err  = 1'b0;
  logic m_fe   = 1'b0;
  int   m_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_update(input logic r, v, b, f, ordy);
    int code;
    m_fe = 1'b0;
    if (r) begin
      m_q.delete();
      m_hold = 1'b0;
      m_cnt  = 0;
      m_bcd  = 0;
      m_err  = 1'b0;
    end else if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      if (f) begin
        if (m_q.size() != 0) begin
          m_fe = 1'b1;
          m_cnt++;
        end
        m_q.delete();
        m_q.push_back(int'(b));
      end else if (m_q.size() == 0) begin
        m_fe = 1'b1;
        m_cnt++;
      end else begin
        m_q.push_back(int'(b));
        if (m_q.size() == 4) begin
          code = m_q[0] * 8 + m_q[1] * 4 + m_q[2] * 2 + m_q[3];
          if (code >= 3 && code <= 12) begin
            m_bcd = code - 3;
            m_err = 1'b0;
          end else begin
            m_bcd = 0;
            m_err = 1'b1;
            m_cnt++;
          end
          m_hold = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic compare_model();
    check("s_ready", int'(s_ready), int'(!m_hold));
    check("out_valid", int'(out_valid), int'(m_hold));
    check("frame_err", int'(frame_err), int'(m_fe));
    check("err_count", int'(err_count), (m_cnt > 255) ? 255 : m_cnt);
    check("err_count_w2", int'(err_count2), (m_cnt > 3) ? 3 : m_cnt);
    if (m_hold) begin
      check("bcd", int'(bcd), m_bcd);
      check("out_err", int'(out_err), int'(m_err));
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic r, v, b, f, ordy);
    rst       = r;
    s_valid   = v;
    s_bit     = b;
    s_first   = f;
    out_ready = ordy;
    @(posedge clk);
    model_update(r, v, b, f, ordy);
    #1;
    compare_model();
  endtask

  task automatic send_frame(input logic [3:0] code, input logic ordy);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, code[i], (i == 3), ordy);
    end
  endtask

  typedef struct {
    logic r, v, b, f, ordy;
    logic e_ready, e_valid;
    int   e_bcd;
    logic e_err, e_fe;
    int   e_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int fe_pulses;
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_first = 1'b0; out_ready = 1'b0;

    //           r     v     b     f     ordy  rdy   vld   bcd err   fe    cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].f, tbl[i].ordy);
      check($sformatf("tbl%0d_s_ready", i), int'(s_ready), int'(tbl[i].e_ready));
      check($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      check($sformatf("tbl%0d_frame_err", i), int'(frame_err), int'(tbl[i].e_fe));
      check($sformatf("tbl%0d_err_count", i), int'(err_count), tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_bcd", i), int'(bcd), tbl[i].e_bcd);
        check($sformatf("tbl%0d_out_err", i), int'(out_err), int'(tbl[i].e_err));
      end
    end

    // Aborted frame restarted by a new s_first, new frame 0011.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fe_pulses = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); fe_pulses += int'(frame_err);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); fe_pulses += int'(frame_err);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1); fe_pulses += int'(frame_err);
    check("abort_fe_now", int'(frame_err), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); fe_pulses += int'(frame_err);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); fe_pulses += int'(frame_err);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1); fe_pulses += int'(frame_err);
    check("abort_fe_pulses", fe_pulses, 1);
    check("abort_valid", int'(out_valid), 1);
    check("abort_bcd", int'(bcd), 0);
    check("abort_err", int'(out_err), 0);
    check("abort_cnt", int'(err_count), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Frame 0110 held under backpressure with s_valid toggling.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, logic'(i % 2 == 0), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b0);
      check("hold_bcd", int'(bcd), 3);
      check("hold_valid", int'(out_valid), 1);
      check("hold_ready", int'(s_ready), 0);
      check("hold_fe", int'(frame_err), 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hold_release", int'(out_valid), 0);
    check("hold_release_rdy", int'(s_ready), 1);

    // Reset after three bits discards the frame.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_ready", int'(s_ready), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_mid_no_valid", int'(out_valid), 0);
    send_frame(4'b1100, 1'b1);
    check("rst_next_bcd", int'(bcd), 9);
    check("rst_next_valid", int'(out_valid), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Five invalid frames saturate the 2-bit counter.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_frame(4'b1111, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("sat_w2", int'(err_count2), 3);
    check("sat_w8", int'(err_count), 5);

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) == 0),
           logic'($urandom_range(0, 9) < 7),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 9) < 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
